// File: rtl/uart6551_rx.sv
// uart6551_rx: 16x-oversampled UART receiver with a small character queue.
// Each queued entry carries {brk, fe, pe, data}. The queue is DEPTH deep in
// FIFO mode and behaves as a single holding register otherwise.
module uart6551_rx #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RTS_THRESH = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cyc,
  input  logic       cs,
  input  logic       rd,
  output logic       ack,
  output logic [7:0] dout,
  input  logic       fifoEnable,
  input  logic       fifoClear,
  input  logic       clear,
  input  logic [3:0] wordLength,
  input  logic [2:0] parityCtrl,
  input  logic       baud16x_ce,
  input  logic       rxd,
  input  logic       statRd,
  output logic       parityErr,
  output logic       frameErr,
  output logic       rxBreak,
  output logic       overrun,
  output logic       full,
  output logic       empty,
  output logic [4:0] qcnt,
  output logic       rts,
  output logic       busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, CNT = 1'b1} state_t;

  // Expected parity bit, same encoding as the transmitter: odd, even, mark, space.
  function automatic logic exp_parity(input logic [7:0] d, input logic [1:0] mode);
    logic p;
    case (mode)
      2'b00:   p = ~^d;
      2'b01:   p = ^d;
      2'b10:   p = 1'b1;
      2'b11:   p = 1'b0;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            par_q, par_d;
  logic            rd_prev_q, rd_prev_d;
  logic            overrun_q, overrun_d;
  logic [4:0]      count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [10:0]     mem [DEPTH];

  logic            rs_s, par_en_s, push_req_s, push_ok_s, pop_s;
  logic            full_s, empty_s, rd_ack_s, pe_rd_s;
  logic            fe_s, pe_s, brk_s, we_s;
  logic [3:0]      wl_s, k_s, stop_idx_s;
  logic [4:0]      cap_s;
  logic [AW-1:0]   waddr_s;
  logic [10:0]     entry_s, head_s;

  assign sync_d     = {sync_q[0], rxd};
  assign rs_s       = sync_q[1];
  assign wl_s       = ((wordLength >= 4'd5) && (wordLength <= 4'd8)) ? wordLength : 4'd8;
  assign par_en_s   = parityCtrl[0];
  assign k_s        = cnt_q[7:4];
  assign stop_idx_s = 4'd1 + wl_s + {3'b000, par_en_s};

  // Frame evaluation at the stop sample; data is already complete in data_q.
  assign fe_s    = ~rs_s;
  assign pe_s    = par_en_s & (par_q != exp_parity(data_q, parityCtrl[2:1]));
  assign brk_s   = fe_s & (data_q == 8'd0) & ~(par_en_s & par_q);
  assign entry_s = {brk_s, fe_s, pe_s, data_q};

  assign rd_ack_s  = cyc & cs & rd;
  assign rd_prev_d = rd_ack_s;
  assign pe_rd_s   = rd_ack_s & ~rd_prev_q;

  assign cap_s     = fifoEnable ? 5'(DEPTH) : 5'd1;
  assign full_s    = (count_q == cap_s);
  assign empty_s   = (count_q == 5'd0);
  assign pop_s     = pe_rd_s & ~empty_s;
  assign push_ok_s = push_req_s & (~full_s | pop_s);
  assign head_s    = mem[rd_ptr_q];

  // Receive state machine: start detect, mid-bit sampling, stop evaluation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    par_d      = par_q;
    push_req_s = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else if (baud16x_ce) begin
      case (state_q)
        IDLE: begin
          if (!rs_s) begin
            state_d = CNT;
            cnt_d   = 8'd0;
            data_d  = 8'd0;
            par_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        CNT: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q[3:0] == 4'd7) begin
            if (k_s == 4'd0) begin
              if (rs_s) begin
                state_d = IDLE;
                cnt_d   = 8'd0;
              end else begin
                state_d = CNT;
              end
            end else if (k_s == stop_idx_s) begin
              push_req_s = 1'b1;
              state_d    = IDLE;
              cnt_d      = 8'd0;
            end else if (par_en_s && (k_s == (wl_s + 4'd1))) begin
              par_d = rs_s;
            end else if (k_s <= wl_s) begin
              data_d[3'(k_s - 4'd1)] = rs_s;
            end else begin
              data_d = data_q;
            end
          end else begin
            state_d = CNT;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Queue pointers, occupancy and overrun flag; flushes beat push/pop.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    we_s      = 1'b0;
    waddr_s   = wr_ptr_q;
    overrun_d = overrun_q;
    if (clear) begin
      rd_ptr_d  = {AW{1'b0}};
      wr_ptr_d  = {AW{1'b0}};
      count_d   = 5'd0;
      overrun_d = 1'b0;
    end else if (fifoClear) begin
      // A frame finishing in the flush cycle lands in the emptied queue.
      rd_ptr_d  = {AW{1'b0}};
      overrun_d = 1'b0;
      if (push_req_s) begin
        we_s     = 1'b1;
        waddr_s  = {AW{1'b0}};
        wr_ptr_d = AW'(1);
        count_d  = 5'd1;
      end else begin
        wr_ptr_d = {AW{1'b0}};
        count_d  = 5'd0;
      end
    end else begin
      if (push_ok_s) begin
        we_s     = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        we_s = 1'b0;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_ok_s && !pop_s) begin
        count_d = count_q + 5'd1;
      end else if (pop_s && !push_ok_s) begin
        count_d = count_q - 5'd1;
      end else begin
        count_d = count_q;
      end
      if (push_req_s && !push_ok_s) begin
        overrun_d = 1'b1;
      end else if (statRd) begin
        overrun_d = 1'b0;
      end else begin
        overrun_d = overrun_q;
      end
    end
  end

  // State, synchronizer and queue control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      cnt_q     <= 8'd0;
      data_q    <= 8'd0;
      par_q     <= 1'b0;
      rd_prev_q <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= 5'd0;
      rd_ptr_q  <= {AW{1'b0}};
      wr_ptr_q  <= {AW{1'b0}};
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_q     <= par_d;
      rd_prev_q <= rd_prev_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // Queue storage; contents are only visible through a non-empty head.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[waddr_s] <= entry_s;
    end
  end

  assign ack       = cyc & cs;
  assign dout      = empty_s ? 8'd0 : head_s[7:0];
  assign parityErr = ~empty_s & head_s[8];
  assign frameErr  = ~empty_s & head_s[9];
  assign rxBreak   = ~empty_s & head_s[10];
  assign overrun   = overrun_q;
  assign full      = full_s;
  assign empty     = empty_s;
  assign qcnt      = count_q;
  assign rts       = fifoEnable ? (count_q < 5'(RTS_THRESH)) : ~full_s;
  assign busy      = (state_q == CNT);

endmodule

// File: tb/tb_uart6551_rx.sv
// Scoreboard bench for uart6551_rx: stimulus queues expected entries, a bus
// monitor checks every popped head entry against the queue front.
module tb_uart6551_rx;

  logic       clk, rst_n, cyc, cs, rd, ack;
  logic [7:0] dout;
  logic       fifoEnable, fifoClear, clear;
  logic [3:0] wordLength;
  logic [2:0] parityCtrl;
  logic       baud16x_ce, rxd, statRd;
  logic       parityErr, frameErr, rxBreak, overrun, full, empty;
  logic [4:0] qcnt;
  logic       rts, busy;

  int tests = 0;
  int fails = 0;
  logic [10:0] sb[$];

  uart6551_rx #(.DEPTH(16), .RTS_THRESH(14)) dut (
    .clk(clk), .rst_n(rst_n), .cyc(cyc), .cs(cs), .rd(rd), .ack(ack),
    .dout(dout), .fifoEnable(fifoEnable), .fifoClear(fifoClear),
    .clear(clear), .wordLength(wordLength), .parityCtrl(parityCtrl),
    .baud16x_ce(baud16x_ce), .rxd(rxd), .statRd(statRd),
    .parityErr(parityErr), .frameErr(frameErr), .rxBreak(rxBreak),
    .overrun(overrun), .full(full), .empty(empty), .qcnt(qcnt),
    .rts(rts), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 16x enable: one clk out of every four, changed on the falling edge.
  initial begin
    baud16x_ce = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud16x_ce = 1'b1;
      @(negedge clk);
      baud16x_ce = 1'b0;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] ent(input bit b, input bit f, input bit p, input logic [7:0] d);
    return {b, f, p, d};
  endfunction

  // Monitor: each rising edge of ack&rd on a non-empty queue presents one entry.
  initial begin
    logic now_rd, prev_rd;
    logic [10:0] exp;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      now_rd = cyc & cs & rd;
      if (now_rd && !prev_rd && rst_n && !empty) begin
        if (sb.size() == 0) begin
          check("unexpected_entry", {5'd0, rxBreak, frameErr, parityErr, dout}, 16'hFFFF);
        end else begin
          exp = sb.pop_front();
          check("pop_entry", {5'd0, rxBreak, frameErr, parityErr, dout}, {5'd0, exp});
        end
      end
      prev_rd = now_rd;
    end
  end

  task automatic line(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  // 64 clk per bit; a 0 stop bit is released early so no second start follows.
  task automatic send_frame(input logic [7:0] d, input int w, input bit has_par,
                            input bit pbit, input bit stopb);
    line(1'b0, 64);
    for (int i = 0; i < w; i++) line(d[i], 64);
    if (has_par) line(pbit, 64);
    if (stopb) line(1'b1, 64);
    else begin
      line(1'b0, 48);
      line(1'b1, 16);
    end
    line(1'b1, 128);
  endtask

  task automatic do_read();
    @(negedge clk);
    cyc = 1'b1; cs = 1'b1; rd = 1'b1;
    @(negedge clk);
    cyc = 1'b0; cs = 1'b0; rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_statrd();
    @(negedge clk);
    statRd = 1'b1;
    @(negedge clk);
    statRd = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_dout"},    {8'd0, dout}, 16'd0);
    check({tag, "_empty"},   {15'd0, empty}, 16'd1);
    check({tag, "_full"},    {15'd0, full}, 16'd0);
    check({tag, "_qcnt"},    {11'd0, qcnt}, 16'd0);
    check({tag, "_flags"},   {13'd0, rxBreak, frameErr, parityErr}, 16'd0);
    check({tag, "_overrun"}, {15'd0, overrun}, 16'd0);
    check({tag, "_rts"},     {15'd0, rts}, 16'd1);
    check({tag, "_busy"},    {15'd0, busy}, 16'd0);
  endtask

  // Raise rd in exactly the stop-sample cycle of an 8N1 frame: that cycle is
  // the 152nd enable after the one that took the start (busy rising edge).
  task automatic collide_read();
    bit found;
    int n;
    found = 1'b0;
    for (int t = 0; t < 3000 && !found; t++) begin
      @(posedge clk);
      #1;
      if (busy) found = 1'b1;
    end
    check("collide_start", {15'd0, found}, 16'd1);
    if (found) begin
      n = 0;
      while (n < 151) begin
        @(posedge clk);
        if (baud16x_ce) n++;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      cyc = 1'b1; cs = 1'b1; rd = 1'b1;
      @(negedge clk);
      cyc = 1'b0; cs = 1'b0; rd = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b1; cyc = 1'b0; cs = 1'b0; rd = 1'b0;
    fifoEnable = 1'b1; fifoClear = 1'b0; clear = 1'b0;
    wordLength = 4'd8; parityCtrl = 3'b000; rxd = 1'b1; statRd = 1'b0;
    #2 rst_n = 1'b0;
    #3 check_reset_vals("rst");
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1: two characters, then drain one at a time.
    sb.push_back(ent(1'b0, 1'b0, 1'b0, 8'h55));
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
    sb.push_back(ent(1'b0, 1'b0, 1'b0, 8'hA3));
    send_frame(8'hA3, 8, 1'b0, 1'b0, 1'b1);
    check("8n1_qcnt2", {11'd0, qcnt}, 16'd2);
    do_read();
    check("8n1_qcnt1", {11'd0, qcnt}, 16'd1);
    do_read();
    check("8n1_qcnt0", {11'd0, qcnt}, 16'd0);

    // 7E1 0x41 (two ones): even expects ^d = 0, so a 1 is a parity error.
    wordLength = 4'd7; parityCtrl = 3'b011;
    sb.push_back(ent(1'b0, 1'b0, 1'b1, 8'h41));
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    check("7e1_pe", {15'd0, parityErr}, 16'd1);
    do_read();
    // 5O1 0x1F (five ones): odd expects ~^d = 0, which is sent.
    wordLength = 4'd5; parityCtrl = 3'b001;
    sb.push_back(ent(1'b0, 1'b0, 1'b0, 8'h1F));
    send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b1);
    check("5o1_dout", {8'd0, dout}, 16'h001F);
    do_read();

    // Framing error and break, 8N1.
    wordLength = 4'd8; parityCtrl = 3'b000;
    sb.push_back(ent(1'b0, 1'b1, 1'b0, 8'h5A));
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0);
    check("fe_flag", {15'd0, frameErr}, 16'd1);
    do_read();
    sb.push_back(ent(1'b1, 1'b1, 1'b0, 8'h00));
    @(negedge clk);
    line(1'b0, 624);
    line(1'b1, 256);
    check("brk_flag", {15'd0, rxBreak}, 16'd1);
    check("brk_qcnt", {11'd0, qcnt}, 16'd1);
    check("brk_busy", {15'd0, busy}, 16'd0);
    do_read();

    // Short low glitch: start taken, rejected at the first mid-bit sample.
    line(1'b0, 16);
    check("glitch_busy1", {15'd0, busy}, 16'd1);
    line(1'b1, 200);
    check("glitch_busy0", {15'd0, busy}, 16'd0);
    check("glitch_empty", {15'd0, empty}, 16'd1);

    // Holding-register mode: second frame is lost.
    fifoEnable = 1'b0;
    sb.push_back(ent(1'b0, 1'b0, 1'b0, 8'h11));
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    check("hold_full", {15'd0, full}, 16'd1);
    check("hold_rts", {15'd0, rts}, 16'd0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    check("hold_overrun", {15'd0, overrun}, 16'd1);
    check("hold_qcnt", {11'd0, qcnt}, 16'd1);
    check("hold_dout", {8'd0, dout}, 16'h0011);
    pulse_statrd();
    check("hold_ovr_clr", {15'd0, overrun}, 16'd0);
    do_read();
    check("hold_empty", {15'd0, empty}, 16'd1);

    // FIFO mode: 17 frames into 16 entries; rts drops at 14 queued.
    fifoEnable = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) sb.push_back(ent(1'b0, 1'b0, 1'b0, 8'h30 + 8'(i)));
      send_frame(8'h30 + 8'(i), 8, 1'b0, 1'b0, 1'b1);
      if (i < 16) check($sformatf("fifo_rts_%0d", i + 1), {15'd0, rts},
                        (i + 1 >= 14) ? 16'd0 : 16'd1);
    end
    check("fifo_qcnt16", {11'd0, qcnt}, 16'd16);
    check("fifo_full", {15'd0, full}, 16'd1);
    check("fifo_overrun", {15'd0, overrun}, 16'd1);
    pulse_statrd();
    check("fifo_ovr_clr", {15'd0, overrun}, 16'd0);

    // Push and pop in the same cycle on a full queue: nothing lost.
    sb.push_back(ent(1'b0, 1'b0, 1'b0, 8'h77));
    fork
      send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1);
      collide_read();
    join
    check("coll_qcnt", {11'd0, qcnt}, 16'd16);
    check("coll_overrun", {15'd0, overrun}, 16'd0);
    check("coll_head", {8'd0, dout}, 16'h0031);

    // Asynchronous reset in the middle of a frame.
    line(1'b0, 100);
    check("midrst_busy", {15'd0, busy}, 16'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    sb.delete();
    @(negedge clk);
    line(1'b1, 20);
    rst_n = 1'b1;
    line(1'b1, 20);
    sb.push_back(ent(1'b0, 1'b0, 1'b0, 8'hC3));
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    check("post_rst_qcnt", {11'd0, qcnt}, 16'd1);
    do_read();
    check("sb_drained", 16'(sb.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
